// File: rtl/mult_pkg.sv
// Shared widths for the unsigned multiplier datapath.
package mult_pkg;
  localparam int OP_W   = 32;
  localparam int PROD_W = 64;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the 3:2 cell of the reduction tree.
// Ports:
//   a, b, cin : input bits of equal weight
//   sum       : output bit, same weight as the inputs
//   cout      : output bit, weight doubled
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/create.sv
// Unsigned 32x32 -> 64-bit Wallace-tree multiplier with a registered product.
// The AND-array partial products are reduced by carry-save stages to two rows,
// which a carry-propagate adder combines in front of the single output register.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears s
//   a   : multiplicand, unsigned
//   b   : multiplier, unsigned
//   s   : a*b, registered (one cycle latency, one result per cycle)
module create
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] s
);

  localparam int N_STAGES = 8;

  // Rows left after st stages: each group of 3 rows becomes 2, leftovers pass.
  // Gives 32, 22, 15, 10, 7, 5, 4, 3, 2.
  function automatic int rows_at(input int st);
    int n;
    n = OP_W;
    for (int i = 0; i < st; i++) n = 2 * (n / 3) + (n % 3);
    return n;
  endfunction

  // rows[st][r] is row r entering stage st; entries past the live row count are tied to 0.
  logic [PROD_W-1:0] rows [0:N_STAGES][0:OP_W-1];

  for (genvar i = 0; i < OP_W; i++) begin : g_pp
    assign rows[0][i] = {{OP_W{1'b0}}, a & {OP_W{b[i]}}} << i;
  end

  for (genvar st = 0; st < N_STAGES; st++) begin : g_stage
    localparam int N_IN  = rows_at(st);
    localparam int N_GRP = N_IN / 3;
    localparam int N_OUT = rows_at(st + 1);

    for (genvar k = 0; k < N_GRP; k++) begin : g_csa
      logic [PROD_W-1:0] sum_row;
      logic [PROD_W-2:0] cry_row;

      for (genvar bt = 0; bt < PROD_W - 1; bt++) begin : g_bit
        full_adder u_fa (
          .a   (rows[st][3*k][bt]),
          .b   (rows[st][3*k+1][bt]),
          .cin (rows[st][3*k+2][bt]),
          .sum (sum_row[bt]),
          .cout(cry_row[bt])
        );
      end

      // A carry out of the top column has weight 2^64; the sum is kept
      // modulo 2^64 and the true product always fits, so only the sum is needed.
      assign sum_row[PROD_W-1] = rows[st][3*k][PROD_W-1] ^ rows[st][3*k+1][PROD_W-1]
                               ^ rows[st][3*k+2][PROD_W-1];

      assign rows[st+1][2*k]   = sum_row;
      assign rows[st+1][2*k+1] = {cry_row, 1'b0};
    end

    for (genvar r = 3 * N_GRP; r < N_IN; r++) begin : g_pass
      assign rows[st+1][r - N_GRP] = rows[st][r];
    end

    for (genvar r = N_OUT; r < OP_W; r++) begin : g_zero
      assign rows[st+1][r] = '0;
    end
  end

  logic [PROD_W-1:0] prod;

  assign prod = rows[N_STAGES][0] + rows[N_STAGES][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s <= '0;
    else     s <= prod;
  end

endmodule

// File: tb/tb_create.sv
module tb_create;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] s;

  int n_tests;
  int n_fail;

  create u_dut (
    .clk(clk),
    .rst(rst),
    .a  (a),
    .b  (b),
    .s  (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Rising edge, then let the register settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_check(input string tag, input logic [31:0] va, input logic [31:0] vb,
                             input logic [63:0] exp);
    a = va;
    b = vb;
    tick();
    check(tag, s, exp);
  endtask

  logic [31:0] vec_a [5];
  logic [31:0] vec_b [5];
  logic [63:0] vec_p [5];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    a   = 32'h0;
    b   = 32'h0;
    #1;
    check("reset_async", s, 64'h0);
    tick();
    check("reset_hold", s, 64'h0);
    #2;
    rst = 1'b0;

    drive_check("ident_1x1",   32'h00000001, 32'h00000001, 64'h0000000000000001);
    drive_check("ident_max_1", 32'hFFFFFFFF, 32'h00000001, 64'h00000000FFFFFFFF);
    drive_check("zero",        32'h00000000, 32'hDEADBEEF, 64'h0000000000000000);
    drive_check("max_max",     32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    drive_check("carry_mid",   32'h00010000, 32'h00010000, 64'h0000000100000000);
    drive_check("carry_msb",   32'h80000000, 32'h00000002, 64'h0000000100000000);

    // Reset asserted between edges clears s at once and holds it.
    drive_check("pre_reset",   32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    #2;
    rst = 1'b1;
    #1;
    check("mid_reset_clear", s, 64'h0);
    tick();
    check("mid_reset_hold1", s, 64'h0);
    tick();
    check("mid_reset_hold2", s, 64'h0);
    #2;
    rst = 1'b0;
    #1;
    check("post_release_pre_edge", s, 64'h0);
    tick();
    check("post_release_load", s, 64'hFFFFFFFE00000001);

    // Back-to-back operands, one per cycle.
    vec_a[0] = 32'h00000003; vec_b[0] = 32'h00000007; vec_p[0] = 64'h0000000000000015;
    vec_a[1] = 32'h0000FFFF; vec_b[1] = 32'h0000FFFF; vec_p[1] = 64'h00000000FFFE0001;
    vec_a[2] = 32'h12345678; vec_b[2] = 32'h00000010; vec_p[2] = 64'h0000000123456780;
    vec_a[3] = 32'hFFFFFFFF; vec_b[3] = 32'h00000002; vec_p[3] = 64'h00000001FFFFFFFE;
    vec_a[4] = 32'h80000000; vec_b[4] = 32'h80000000; vec_p[4] = 64'h4000000000000000;
    for (int i = 0; i < 5; i++) begin
      drive_check($sformatf("b2b_%0d", i), vec_a[i], vec_b[i], vec_p[i]);
    end

    for (int i = 0; i < 10000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [63:0] rp;
      ra = $urandom;
      rb = $urandom;
      rp = {32'b0, ra} * {32'b0, rb};
      drive_check($sformatf("rand_%0d", i), ra, rb, rp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
